uart_rx_os: RTL
===============

// Module: uart_rx_os
// PURPOSE
//  Oversampling UART receiver: recovers 8N1/8E1/8O1 frames from the asynchronous i_rx pin.
//  Runs in the system clock domain, driven by a baud-rate clock-enable tick.
//  Sits between the pad and the UART RX FIFO; each frame yields one valid pulse plus error flags.
//  Also reports frame error, parity error and line break to the UART status register.
// PARAMETERS
//  OS           16  ticks per bit; even, >= 8
//  DATA_W        8  data bits per frame, LSB first
//  SYNC_STAGES   2  flops in i_rx synchroniser, >= 2
// PORTS
//  i_clk         in   1       system clock
//  i_rstn        in   1       async active-low reset
//  i_tick        in   1       OS x baud enable, 1-cycle pulse in i_clk domain
//  i_en          in   1       receiver enable
//  i_parity_en   in   1       1 = parity bit present after data
//  i_parity_odd  in   1       1 = odd parity, 0 = even (ignored when i_parity_en=0)
//  i_rx          in   1       serial input, async, idle high
//  o_rx_data     out  DATA_W  last received byte, held until next frame completes
//  o_rx_valid    out  1       1-cycle pulse: frame complete, o_rx_data/errs valid
//  o_frame_err   out  1       stop bit sampled 0; qualified by o_rx_valid
//  o_parity_err  out  1       parity mismatch; qualified by o_rx_valid
//  o_break       out  1       1-cycle pulse: all-zero data + zero stop bit
//  o_busy        out  1       state != IDLE
// BEHAVIOUR
//  Reset: sync chain = all 1; state IDLE; s_cnt = 0; bit_cnt = 0; every output 0.
//  Sync: i_rx passes SYNC_STAGES flops -> rx_s; rx_q = rx_s delayed by 1 i_clk cycle.
//  Sampling: s_cnt increments only on i_tick. Majority vote over rx_s taken at 3 consecutive ticks.
//  States and transitions:
//   IDLE: when rx_q=1 and rx_s=0 -> START, s_cnt=0.
//   START: vote at s_cnt = OS/2-3 .. OS/2-1; decision on tick with s_cnt = OS/2-1.
//     Vote 1 (false start) -> IDLE, no outputs. Vote 0 -> DATA, s_cnt=0, bit_cnt=0.
//   DATA: vote at s_cnt = OS-3 .. OS-1; on tick with s_cnt = OS-1, shift the bit in, s_cnt=0.
//     After bit DATA_W-1 -> PARITY if i_parity_en, else STOP.
//   PARITY: same timing. perr = (^data ^ bit) != i_parity_odd.
//   STOP: same timing. Decision cycle (next i_clk edge after the decision tick):
//     o_rx_valid=1 and o_rx_data updated.
//     o_frame_err = ~stop; o_parity_err = perr & i_parity_en.
//     o_break = ~stop & (data == 0).
//     stop = 1 -> IDLE. stop = 0 -> BRK_WAIT.
//   BRK_WAIT: stay until rx_s = 1, then IDLE. No start detection in this state.
//  Error flags are registered with o_rx_valid and are 0 in every other cycle.
//  Latency: o_rx_valid rises 1 i_clk cycle after the stop decision tick.
//  Back-to-back: a falling edge is accepted on the first cycle in IDLE after STOP; no idle bit needed.
//  i_en = 0: state -> IDLE and counters -> 0 on next edge. No pulses. o_rx_data holds.
//  i_parity_en / i_parity_odd are sampled at the parity decision; software changes them only while idle.
//  i_tick absent: FSM frozen in its current state.
//  Reset mid-frame: immediate return to reset values; partial byte discarded.
//  Widths: s_cnt = clog2(OS); bit_cnt = clog2(DATA_W+1); no wrap beyond OS-1.
// TESTING (OS=16, i_tick every 4 clk => 64 clk/bit, i_en=1)
//  1 8N1 frame 0xA5, good stop -> one o_rx_valid pulse, o_rx_data=0xA5, both errs 0, o_busy falls.
//  2 i_rx low for 2 ticks in IDLE -> START then IDLE; no o_rx_valid; o_busy high < 9 ticks.
//  3 Even parity, data 0x0F, parity bit 1 -> o_rx_valid with o_parity_err=1, data 0x0F.
//    Same with parity bit 0 -> o_parity_err=0.
//  4 Data 0x55, stop bit 0 -> o_frame_err=1, o_break=0.
//    Line low for 20 bit times -> o_break pulse with data 0x00.
//    FSM holds in BRK_WAIT until line high; no further frames.
//  5 i_rstn low at data bit 3 of 0x3C, then frame 0xC3 -> outputs reset; single valid, data 0xC3.
//  6 Frames 0x01 and 0xFE with no idle gap -> two valid pulses 10 bit times apart, no errors.
//    Single-tick glitch mid data bit -> majority vote rejects it.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os
//   Oversampling UART receiver for 8N1 / 8E1 / 8O1 frames (DATA_W data bits,
//   LSB first). The asynchronous i_rx pin is synchronised and then sampled on
//   each i_tick, where i_tick is an OS x baud clock enable. Each bit is decided
//   by a 3-sample majority vote around its centre. Every completed frame gives
//   one o_rx_valid pulse, along with the frame-error, parity-error and break
//   flags for that frame.
//
// Ports
//   i_clk         system clock
//   i_rstn        asynchronous active-low reset
//   i_tick        OS x baud enable, one i_clk cycle wide
//   i_en          receiver enable; when low, returns to IDLE
//   i_parity_en   a parity bit follows the data bits
//   i_parity_odd  1 = odd parity, 0 = even parity
//   i_rx          serial input, asynchronous, idle high
//   o_rx_data     last received data word, held until the next frame completes
//   o_rx_valid    one-cycle pulse when a frame completes
//   o_frame_err   stop bit sampled low (only meaningful with o_rx_valid)
//   o_parity_err  parity mismatch (only meaningful with o_rx_valid)
//   o_break       one-cycle pulse: all-zero data and a zero stop bit
//   o_busy        receiver is not idle
module uart_rx_os #(
    parameter int OS          = 16,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_tick,
    input  logic              i_en,
    input  logic              i_parity_en,
    input  logic              i_parity_odd,
    input  logic              i_rx,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_frame_err,
    output logic              o_parity_err,
    output logic              o_break,
    output logic              o_busy
);

    localparam int CW = $clog2(OS);
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] START_LAST = CW'(OS / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(OS - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_q;
    logic [1:0]             vote_q;
    logic                   maj;

    logic [CW-1:0]     s_cnt, s_cnt_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              perr_q, perr_n;

    logic [DATA_W-1:0] data_n;
    logic              valid_n, ferr_n, pe_n, brk_n;

    // Input synchroniser and one-cycle delayed copy used for edge detection.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q <= '1;
            rx_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
            rx_q   <= rx_s;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // The two most recent tick samples. Because they are taken on every tick,
    // at a decision tick they are exactly the samples from s_cnt-2 and s_cnt-1.
    // Together with the live rx_s they make up the three-sample vote window.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vote_q <= '1;
        end else if (i_tick) begin
            vote_q <= {vote_q[0], rx_s};
        end
    end

    assign maj = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Counters, shift register and the registered frame outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s_cnt        <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            perr_q       <= 1'b0;
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            s_cnt        <= s_cnt_n;
            bit_cnt      <= bit_cnt_n;
            shreg        <= shreg_n;
            perr_q       <= perr_n;
            o_rx_data    <= data_n;
            o_rx_valid   <= valid_n;
            o_frame_err  <= ferr_n;
            o_parity_err <= pe_n;
            o_break      <= brk_n;
        end
    end

    // Next-state logic and next values for the frame outputs.
    always_comb begin
        state_n   = state;
        s_cnt_n   = s_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        perr_n    = perr_q;
        data_n    = o_rx_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        pe_n      = 1'b0;
        brk_n     = 1'b0;

        if (!i_en) begin
            state_n   = IDLE;
            s_cnt_n   = '0;
            bit_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_q && !rx_s) begin
                        state_n = START;
                        s_cnt_n = '0;
                    end
                end

                START: begin
                    if (i_tick) begin
                        if (s_cnt == START_LAST) begin
                            s_cnt_n = '0;
                            if (maj) begin
                                state_n = IDLE;
                            end else begin
                                state_n   = DATA;
                                bit_cnt_n = '0;
                            end
                        end else begin
                            s_cnt_n = s_cnt + CW'(1);
                        end
                    end
                end

                DATA, PARITY, STOP: begin
                    if (i_tick) begin
                        if (s_cnt == BIT_LAST) begin
                            s_cnt_n = '0;
                            case (state)
                                DATA: begin
                                    shreg_n   = {maj, shreg[DATA_W-1:1]};
                                    bit_cnt_n = bit_cnt + BW'(1);
                                    if (bit_cnt == LAST_BIT) begin
                                        state_n = i_parity_en ? PARITY : STOP;
                                    end
                                end
                                PARITY: begin
                                    perr_n  = ((^shreg) ^ maj) != i_parity_odd;
                                    state_n = STOP;
                                end
                                default: begin
                                    valid_n = 1'b1;
                                    data_n  = shreg;
                                    ferr_n  = ~maj;
                                    pe_n    = perr_q & i_parity_en;
                                    brk_n   = ~maj & (shreg == '0);
                                    state_n = maj ? IDLE : BRK_WAIT;
                                end
                            endcase
                        end else begin
                            s_cnt_n = s_cnt + CW'(1);
                        end
                    end
                end

                BRK_WAIT: begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign o_busy = (state != IDLE);

endmodule
